// File: rtl/ref_model_step_pkg.sv
// ---------------------------------------------------------------------------
// ref_model_step_pkg: shared types for the ISS step controller.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ref_model_step_pkg;

  localparam int unsigned ORDER_W = 64;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic               intr;
  } retire_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } step_state_e;

endpackage

`default_nettype wire

// File: rtl/ref_model_retire_fifo.sv
// ---------------------------------------------------------------------------
// ref_model_retire_fifo: multi-push, single-pop retirement queue.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ref_model_retire_fifo
  import ref_model_step_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic          [NRET-1:0]       push_valid_i,
  input  retire_entry_t [NRET-1:0]       push_data_i,
  input  logic                           pop_i,
  output retire_entry_t                  head_o,
  output logic                           empty_o,
  output logic                           overflow_o,
  output logic          [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  retire_entry_t mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_valid;
  logic [CW-1:0] free_space;
  logic          pop_ok;
  logic          accept;
  logic [AW-1:0] wr_idx [NRET];

  // Valid ports are packed into consecutive slots in ascending port order.
  always_comb begin
    n_valid = '0;
    for (int p = 0; p < NRET; p++) begin
      wr_idx[p] = wr_ptr_q + AW'(n_valid);
      if (push_valid_i[p]) n_valid = n_valid + CW'(1);
    end
  end

  assign pop_ok     = pop_i && (count_q != '0);
  assign free_space = CW'(DEPTH) - count_q + CW'(pop_ok);
  assign accept     = (n_valid <= free_space);
  assign overflow_o = (n_valid != '0) && !accept;

  assign count_d  = count_q - CW'(pop_ok) + (accept ? n_valid : '0);
  assign wr_ptr_d = accept ? (wr_ptr_q + AW'(n_valid)) : wr_ptr_q;
  assign rd_ptr_d = rd_ptr_q + AW'(pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int p = 0; p < NRET; p++) begin
        if (push_valid_i[p]) mem_q[wr_idx[p]] <= push_data_i[p];
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ref_model_step_ctrl.sv
// ---------------------------------------------------------------------------
// ref_model_step_ctrl: queues DUT retirements and steps the ISS one at a time.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ref_model_step_ctrl
  import ref_model_step_pkg::*;
#(
  parameter int                 NRET       = 2,
  parameter int                 FIFO_DEPTH = 8,
  parameter int                 TIMEOUT    = 1024,
  parameter logic [ORDER_W-1:0] ORDER_INIT = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NRET-1:0]               retire_valid_i,
  input  logic [NRET*ORDER_W-1:0]       retire_order_i,
  input  logic [NRET-1:0]               retire_intr_i,
  input  logic [31:0]                   irq_i,
  output logic                          step_req_o,
  output logic [31:0]                   step_irq_o,
  output logic [ORDER_W-1:0]            step_order_o,
  input  logic                          step_ack_i,
  output logic                          done_valid_o,
  output logic [ORDER_W-1:0]            done_order_o,
  output logic                          overflow_o,
  output logic                          order_err_o,
  output logic                          timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_o
);

  localparam logic [31:0] WAIT_LIMIT = 32'(TIMEOUT - 1);

  retire_entry_t [NRET-1:0] push_data;
  retire_entry_t            head;
  logic                     fifo_empty;
  logic                     fifo_ovf;
  logic                     pop;

  step_state_e        state_q, state_d;
  logic [ORDER_W-1:0] cur_order_q, cur_order_d;
  logic [31:0]        irq_q, irq_d;
  logic [ORDER_W-1:0] expected_q, expected_d;
  logic [31:0]        wait_q, wait_d;
  logic               overflow_q, overflow_d;
  logic               order_err_q, order_err_d;
  logic               timeout_q, timeout_d;

  for (genvar p = 0; p < NRET; p++) begin : g_push
    assign push_data[p] = '{order: retire_order_i[p*ORDER_W +: ORDER_W],
                            intr:  retire_intr_i[p]};
  end

  ref_model_retire_fifo #(
    .NRET  (NRET),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_valid_i (retire_valid_i),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .overflow_o   (fifo_ovf),
    .count_o      (pending_o)
  );

  always_comb begin
    state_d     = state_q;
    cur_order_d = cur_order_q;
    irq_d       = irq_q;
    expected_d  = expected_q;
    wait_d      = wait_q;
    overflow_d  = overflow_q | fifo_ovf;
    order_err_d = order_err_q;
    timeout_d   = timeout_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          cur_order_d = head.order;
          irq_d       = head.intr ? irq_i : '0;
          // Resync and normal advance both land on popped order + 1.
          if (head.order != expected_q) order_err_d = 1'b1;
          expected_d  = head.order + ORDER_W'(1);
          wait_d      = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (step_ack_i) begin
          state_d = ST_DONE;
        end else if (wait_q == WAIT_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cur_order_q <= '0;
      irq_q       <= '0;
      expected_q  <= ORDER_INIT;
      wait_q      <= '0;
      overflow_q  <= 1'b0;
      order_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_order_q <= cur_order_d;
      irq_q       <= irq_d;
      expected_q  <= expected_d;
      wait_q      <= wait_d;
      overflow_q  <= overflow_d;
      order_err_q <= order_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign step_req_o   = (state_q == ST_REQ);
  assign step_order_o = cur_order_q;
  assign step_irq_o   = irq_q;
  assign done_valid_o = (state_q == ST_DONE);
  assign done_order_o = done_valid_o ? cur_order_q : '0;
  assign overflow_o   = overflow_q;
  assign order_err_o  = order_err_q;
  assign timeout_o    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ref_model_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ref_model_step_ctrl: directed checks of the ISS step controller.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ref_model_step_ctrl;

  logic         clk;
  logic         rst_n;
  logic [1:0]   retire_valid;
  logic [127:0] retire_order;
  logic [1:0]   retire_intr;
  logic [31:0]  irq;
  logic         ack;

  logic         a_step_req, a_done_valid, a_ovf, a_oerr, a_to;
  logic [31:0]  a_step_irq;
  logic [63:0]  a_step_order, a_done_order;
  logic [3:0]   a_pending;

  logic         b_step_req, b_done_valid, b_ovf, b_oerr, b_to;
  logic [31:0]  b_step_irq;
  logic [63:0]  b_step_order, b_done_order;
  logic [3:0]   b_pending;

  int n_checks = 0;
  int n_pass   = 0;

  ref_model_step_ctrl #(.NRET(2), .FIFO_DEPTH(8), .TIMEOUT(16), .ORDER_INIT(64'd0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .retire_valid_i(retire_valid), .retire_order_i(retire_order),
    .retire_intr_i(retire_intr), .irq_i(irq), .step_req_o(a_step_req), .step_irq_o(a_step_irq),
    .step_order_o(a_step_order), .step_ack_i(ack), .done_valid_o(a_done_valid),
    .done_order_o(a_done_order), .overflow_o(a_ovf), .order_err_o(a_oerr), .timeout_o(a_to),
    .pending_o(a_pending));

  ref_model_step_ctrl #(.NRET(2), .FIFO_DEPTH(8), .TIMEOUT(16), .ORDER_INIT(64'd5)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .retire_valid_i(retire_valid), .retire_order_i(retire_order),
    .retire_intr_i(retire_intr), .irq_i(irq), .step_req_o(b_step_req), .step_irq_o(b_step_irq),
    .step_order_o(b_step_order), .step_ack_i(ack), .done_valid_o(b_done_valid),
    .done_order_o(b_done_order), .overflow_o(b_ovf), .order_err_o(b_oerr), .timeout_o(b_to),
    .pending_o(b_pending));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    retire_valid = '0;
    retire_order = '0;
    retire_intr  = '0;
    ack          = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    irq = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq = 32'hFFFF_FFFF;
    retire_valid = 2'b11;
    retire_order = {64'd7, 64'd6};
    ack = 1'b1;
    tick();
    tick();
    n_checks++; if (a_step_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", a_step_req); else n_pass++;
    n_checks++; if (a_done_valid !== 1'b0) $display("FAIL reset_done: got %0b want 0", a_done_valid); else n_pass++;
    n_checks++; if (a_pending !== 4'd0) $display("FAIL reset_pending: got %0d want 0", a_pending); else n_pass++;
    n_checks++; if ({a_ovf, a_oerr, a_to} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {a_ovf, a_oerr, a_to}); else n_pass++;
    n_checks++; if (a_step_irq !== 32'd0 || a_step_order !== 64'd0) $display("FAIL reset_step_outs: got irq %h order %0d want 0 0", a_step_irq, a_step_order); else n_pass++;
    clear_in();
    irq = '0;
  endtask

  task automatic test_single();
    do_reset();
    retire_valid = 2'b01;
    retire_order = '0;
    tick();
    clear_in();
    n_checks++; if (a_pending !== 4'd1 || a_step_req !== 1'b0) $display("FAIL single_push: got pending %0d req %0b want 1 0", a_pending, a_step_req); else n_pass++;
    tick();
    n_checks++; if (a_step_req !== 1'b1 || a_step_order !== 64'd0 || a_pending !== 4'd0) $display("FAIL single_req: got req %0b order %0d pending %0d want 1 0 0", a_step_req, a_step_order, a_pending); else n_pass++;
    tick();
    n_checks++; if (a_step_req !== 1'b1 || a_done_valid !== 1'b0) $display("FAIL single_hold: got req %0b done %0b want 1 0", a_step_req, a_done_valid); else n_pass++;
    ack = 1'b1;
    tick();
    n_checks++; if (a_done_valid !== 1'b1 || a_done_order !== 64'd0 || a_step_req !== 1'b0) $display("FAIL single_done: got done %0b order %0d req %0b want 1 0 0", a_done_valid, a_done_order, a_step_req); else n_pass++;
    ack = 1'b0;
    tick();
    n_checks++; if (a_done_valid !== 1'b0) $display("FAIL single_done_pulse: got %0b want 0", a_done_valid); else n_pass++;
    n_checks++; if ({a_ovf, a_oerr, a_to} !== 3'b000) $display("FAIL single_flags: got %b want 000", {a_ovf, a_oerr, a_to}); else n_pass++;
  endtask

  task automatic test_dual();
    do_reset();
    retire_valid = 2'b11;
    retire_order = {64'd6, 64'd5};
    tick();
    clear_in();
    n_checks++; if (b_pending !== 4'd2) $display("FAIL dual_pending: got %0d want 2", b_pending); else n_pass++;
    tick();
    n_checks++; if (b_step_order !== 64'd5 || b_pending !== 4'd1) $display("FAIL dual_first: got order %0d pending %0d want 5 1", b_step_order, b_pending); else n_pass++;
    ack = 1'b1;
    tick();
    n_checks++; if (b_done_valid !== 1'b1 || b_done_order !== 64'd5) $display("FAIL dual_done5: got %0b %0d want 1 5", b_done_valid, b_done_order); else n_pass++;
    ack = 1'b0;
    tick();
    tick();
    n_checks++; if (b_step_req !== 1'b1 || b_step_order !== 64'd6) $display("FAIL dual_second: got req %0b order %0d want 1 6", b_step_req, b_step_order); else n_pass++;
    ack = 1'b1;
    tick();
    n_checks++; if (b_done_valid !== 1'b1 || b_done_order !== 64'd6) $display("FAIL dual_done6: got %0b %0d want 1 6", b_done_valid, b_done_order); else n_pass++;
    ack = 1'b0;
    tick();
    n_checks++; if (b_oerr !== 1'b0) $display("FAIL dual_no_order_err: got %0b want 0", b_oerr); else n_pass++;
    n_checks++; if (a_oerr !== 1'b1) $display("FAIL dual_order_err_init0: got %0b want 1", a_oerr); else n_pass++;
  endtask

  task automatic test_irq();
    do_reset();
    irq = 32'h800;
    retire_valid = 2'b01;
    retire_order = '0;
    retire_intr = 2'b01;
    tick();
    clear_in();
    tick();
    n_checks++; if (a_step_irq !== 32'h800) $display("FAIL irq_inject: got %h want 800", a_step_irq); else n_pass++;
    irq = '0;
    tick();
    n_checks++; if (a_step_irq !== 32'h800 || a_step_req !== 1'b1) $display("FAIL irq_stable: got %h req %0b want 800 1", a_step_irq, a_step_req); else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    irq = 32'h800;
    retire_valid = 2'b01;
    retire_order = {64'd0, 64'd1};
    retire_intr = 2'b00;
    tick();
    clear_in();
    tick();
    n_checks++; if (a_step_irq !== 32'd0 || a_step_order !== 64'd1) $display("FAIL irq_none: got irq %h order %0d want 0 1", a_step_irq, a_step_order); else n_pass++;
    n_checks++; if (a_oerr !== 1'b0) $display("FAIL irq_order_err: got %0b want 0", a_oerr); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    retire_valid = 2'b01;
    retire_order = '0;
    tick();
    clear_in();
    tick();
    for (int k = 0; k < 4; k++) begin
      retire_valid = 2'b11;
      retire_order = {64'(2*k+2), 64'(2*k+1)};
      tick();
      n_checks++; if (a_pending !== 4'(2*(k+1))) $display("FAIL ovf_fill%0d: got %0d want %0d", k, a_pending, 2*(k+1)); else n_pass++;
    end
    n_checks++; if (a_ovf !== 1'b0) $display("FAIL ovf_early: got %0b want 0", a_ovf); else n_pass++;
    retire_valid = 2'b01;
    retire_order = {64'd0, 64'd9};
    tick();
    clear_in();
    n_checks++; if (a_ovf !== 1'b1 || a_pending !== 4'd8) $display("FAIL ovf_set: got ovf %0b pending %0d want 1 8", a_ovf, a_pending); else n_pass++;
    n_checks++; if (a_step_req !== 1'b1 || a_step_order !== 64'd0) $display("FAIL ovf_held: got req %0b order %0d want 1 0", a_step_req, a_step_order); else n_pass++;
  endtask

  task automatic test_timeout();
    logic seen_done;
    do_reset();
    seen_done = 1'b0;
    retire_valid = 2'b11;
    retire_order = {64'd1, 64'd0};
    tick();
    clear_in();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      if (a_done_valid) seen_done = 1'b1;
    end
    n_checks++; if (a_step_req !== 1'b1 || a_to !== 1'b0) $display("FAIL to_early: got req %0b to %0b want 1 0", a_step_req, a_to); else n_pass++;
    tick();
    if (a_done_valid) seen_done = 1'b1;
    n_checks++; if (a_to !== 1'b1 || a_step_req !== 1'b0) $display("FAIL to_set: got to %0b req %0b want 1 0", a_to, a_step_req); else n_pass++;
    n_checks++; if (seen_done !== 1'b0) $display("FAIL to_no_done: got %0b want 0", seen_done); else n_pass++;
    tick();
    n_checks++; if (a_step_req !== 1'b1 || a_step_order !== 64'd1) $display("FAIL to_next: got req %0b order %0d want 1 1", a_step_req, a_step_order); else n_pass++;
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    retire_valid = 2'b01;
    retire_order = '0;
    tick();
    clear_in();
    tick();
    repeat (15) tick();
    ack = 1'b1;
    tick();
    n_checks++; if (a_done_valid !== 1'b1 || a_to !== 1'b0) $display("FAIL ack_wins: got done %0b to %0b want 1 0", a_done_valid, a_to); else n_pass++;
    ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    retire_valid = 2'b11;
    retire_order = {64'd1, 64'd0};
    tick();
    clear_in();
    ack = 1'b1;
    tick();
    tick();
    n_checks++; if (a_done_valid !== 1'b1 || a_done_order !== 64'd0) $display("FAIL b2b_first: got %0b %0d want 1 0", a_done_valid, a_done_order); else n_pass++;
    tick();
    tick();
    tick();
    n_checks++; if (a_done_valid !== 1'b1 || a_done_order !== 64'd1) $display("FAIL b2b_second: got %0b %0d want 1 1", a_done_valid, a_done_order); else n_pass++;
    ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    retire_valid = 2'b11;
    retire_order = {64'd1, 64'd0};
    tick();
    clear_in();
    tick();
    n_checks++; if (a_step_req !== 1'b1 || a_pending !== 4'd1) $display("FAIL rmid_pre: got req %0b pending %0d want 1 1", a_step_req, a_pending); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_step_req !== 1'b0 || a_pending !== 4'd0) $display("FAIL rmid_async: got req %0b pending %0d want 0 0", a_step_req, a_pending); else n_pass++;
    tick();
    rst_n = 1'b1;
    retire_valid = 2'b01;
    retire_order = '0;
    tick();
    clear_in();
    n_checks++; if (a_pending !== 4'd1) $display("FAIL rmid_first_edge: got %0d want 1", a_pending); else n_pass++;
    tick();
    ack = 1'b1;
    tick();
    n_checks++; if (a_done_valid !== 1'b1 || a_done_order !== 64'd0 || a_oerr !== 1'b0) $display("FAIL rmid_resume: got done %0b order %0d err %0b want 1 0 0", a_done_valid, a_done_order, a_oerr); else n_pass++;
    ack = 1'b0;
    tick();
  endtask

  task automatic test_order_err();
    do_reset();
    retire_valid = 2'b01;
    retire_order = {64'd0, 64'd3};
    tick();
    clear_in();
    n_checks++; if (a_oerr !== 1'b0) $display("FAIL oerr_before_pop: got %0b want 0", a_oerr); else n_pass++;
    tick();
    n_checks++; if (a_oerr !== 1'b1) $display("FAIL oerr_set: got %0b want 1", a_oerr); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear_in();
    irq = '0;
    test_reset();
    test_single();
    test_dual();
    test_irq();
    test_overflow();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid();
    test_order_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
